// File: rtl/cla_seq_ctrl.sv
// Sequencer that builds a WIDTH-bit add from one shared external 4-bit CLA slice, one nibble per cycle.
// Optional subtract support is enabled by defining CLA_SEQ_SUB_EN (adds the req_sub_i port).
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic             req_c_i,
`ifdef CLA_SEQ_SUB_EN
  input  logic             req_sub_i,
`endif
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_sum_o,
  output logic             rsp_c_o,
  output logic             busy_o,
  output logic [3:0]       add_a_o,
  output logic [3:0]       add_b_o,
  output logic             add_c_o,
  input  logic [3:0]       add_sum_i,
  input  logic             add_c_i
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("cla_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   result_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   b_lat_s;
  logic               c_lat_s;

  // Operand B and initial carry as captured on acceptance (inverted B and carry 1 for subtract)
  always_comb begin
    b_lat_s = req_b_i;
    c_lat_s = req_c_i;
`ifdef CLA_SEQ_SUB_EN
    if (req_sub_i) begin
      b_lat_s = ~req_b_i;
      c_lat_s = 1'b1;
    end else begin
      b_lat_s = req_b_i;
      c_lat_s = req_c_i;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) state_nxt_s = ST_RUN;
        else             state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (rsp_ready_i) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one nibble of result and the ripple carry per RUN cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      carry_r  <= 1'b0;
      idx_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            a_r     <= req_a_i;
            b_r     <= b_lat_s;
            carry_r <= c_lat_s;
            idx_r   <= '0;
          end
        end
        ST_RUN: begin
          result_r[{idx_r, 2'b00} +: 4] <= add_sum_i;
          carry_r                       <= add_c_i;
          idx_r <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Handshake/status decode and slice drive, all from registered state
  always_comb begin
    req_ready_o = (state_r == ST_IDLE);
    rsp_valid_o = (state_r == ST_DONE);
    busy_o      = (state_r == ST_RUN) || (state_r == ST_DONE);
    if (state_r == ST_RUN) begin
      add_a_o = a_r[{idx_r, 2'b00} +: 4];
      add_b_o = b_r[{idx_r, 2'b00} +: 4];
      add_c_o = carry_r;
    end else begin
      add_a_o = 4'h0;
      add_b_o = 4'h0;
      add_c_o = 1'b0;
    end
  end

  assign rsp_sum_o = result_r;
  assign rsp_c_o   = carry_r;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench for cla_seq_ctrl: a WIDTH=16 and a WIDTH=4 instance, each with a behavioural 4-bit slice.
module tb_cla_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16-bit instance signals
  logic        v16 = 1'b0, rdy16 = 1'b1, c16 = 1'b0;
  logic [15:0] a16 = 16'h0, b16 = 16'h0;
  logic        ready16, rsp_valid16, rsp_c16, busy16;
  logic [15:0] rsp_sum16;
  logic [3:0]  sa16, sb16, ssum16;
  logic        sc16, sco16;
`ifdef CLA_SEQ_SUB_EN
  logic        sub16 = 1'b0;
  logic        sub4 = 1'b0;
`endif

  // 4-bit instance signals
  logic        v4 = 1'b0, rdy4 = 1'b1, c4 = 1'b0;
  logic [3:0]  a4 = 4'h0, b4 = 4'h0;
  logic        ready4, rsp_valid4, rsp_c4, busy4;
  logic [3:0]  rsp_sum4;
  logic [3:0]  sa4, sb4, ssum4;
  logic        sc4, sco4;

  // external CLA slices
  assign {sco16, ssum16} = {1'b0, sa16} + {1'b0, sb16} + {4'h0, sc16};
  assign {sco4, ssum4}   = {1'b0, sa4} + {1'b0, sb4} + {4'h0, sc4};

  cla_seq_ctrl #(.WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v16), .req_ready_o(ready16),
    .req_a_i(a16), .req_b_i(b16), .req_c_i(c16),
`ifdef CLA_SEQ_SUB_EN
    .req_sub_i(sub16),
`endif
    .rsp_valid_o(rsp_valid16), .rsp_ready_i(rdy16), .rsp_sum_o(rsp_sum16), .rsp_c_o(rsp_c16),
    .busy_o(busy16), .add_a_o(sa16), .add_b_o(sb16), .add_c_o(sc16),
    .add_sum_i(ssum16), .add_c_i(sco16)
  );

  cla_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v4), .req_ready_o(ready4),
    .req_a_i(a4), .req_b_i(b4), .req_c_i(c4),
`ifdef CLA_SEQ_SUB_EN
    .req_sub_i(sub4),
`endif
    .rsp_valid_o(rsp_valid4), .rsp_ready_i(rdy4), .rsp_sum_o(rsp_sum4), .rsp_c_o(rsp_c4),
    .busy_o(busy4), .add_a_o(sa4), .add_b_o(sb4), .add_c_o(sc4),
    .add_sum_i(ssum4), .add_c_i(sco4)
  );

  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  logic        prev16 = 1'b0, prev4 = 1'b0;
  logic        addc_seq[4];
  int          lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every new response is popped against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev16 = 1'b0;
      prev4  = 1'b0;
    end else begin
      if (rsp_valid16 && !prev16) begin
        if (q16.size() == 0) chk("rsp16_unexpected", 32'd1, 32'd0);
        else chk("rsp16_sum_c", {15'd0, rsp_c16, rsp_sum16}, {15'd0, q16.pop_front()});
      end
      if (rsp_valid4 && !prev4) begin
        if (q4.size() == 0) chk("rsp4_unexpected", 32'd1, 32'd0);
        else chk("rsp4_sum_c", {27'd0, rsp_c4, rsp_sum4}, {27'd0, q4.pop_front()});
      end
      prev16 = rsp_valid16;
      prev4  = rsp_valid4;
    end
  end

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic s, input logic [16:0] exp);
    int n;
    n = 0;
    while (!ready16 && n < 50) begin @(posedge clk); #1; n++; end
    chk("req16_ready", {31'd0, ready16}, 32'd1);
    q16.push_back(exp);
    a16 = a; b16 = b; c16 = c; v16 = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    sub16 = s;
`endif
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = -1;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid16) begin lat = n - 1; break; end
      if (n <= 4) addc_seq[n-1] = sc16;
    end
    chk("lat16", lat, 32'd4);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] exp);
    int n;
    n = 0;
    while (!ready4 && n < 50) begin @(posedge clk); #1; n++; end
    q4.push_back(exp);
    a4 = a; b4 = b; c4 = c; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    lat = -1;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid4) begin lat = n - 1; break; end
    end
    chk("lat4", lat, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'd0, ready16}, 32'd1);
    chk("rst_outs", {rsp_valid16, rsp_c16, busy16, sc16, sa16, sb16, rsp_sum16}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    op16(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555);
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
    chk("addc_seq", {28'd0, addc_seq[0], addc_seq[1], addc_seq[2], addc_seq[3]}, 32'b0111);
    op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF);
    op16(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000);
    op16(16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001);
    op16(16'hABCD, 16'h1111, 1'b0, 1'b0, 17'h0BCDE);

    // backpressure: DONE held 10 cycles while a new request is presented and must be ignored
    @(posedge clk); #1;
    rdy16 = 1'b0;
    op16(16'h0F00, 16'h0123, 1'b1, 1'b0, 17'h01024);
    a16 = 16'h1111; b16 = 16'h2222; v16 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {13'd0, rsp_valid16, ready16, rsp_c16, rsp_sum16}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h1024});
    end
    v16 = 1'b0; rdy16 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, rsp_valid16, ready16}, 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("bp_no_accept", {31'd0, busy16}, 32'd0);

    // asynchronous reset after two nibbles of a run
    a16 = 16'h7777; b16 = 16'h7777; c16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1 v16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("midrun_busy", {31'd0, busy16}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", {31'd0, ready16}, 32'd1);
    chk("midrun_rst_outs", {rsp_valid16, rsp_c16, busy16, sc16, sa16, sb16, rsp_sum16}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    op16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000);

    op4(4'hF, 4'hF, 1'b1, 5'h1F);
    op4(4'h3, 4'h4, 1'b0, 5'h07);

`ifdef CLA_SEQ_SUB_EN
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE);
    op16(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002);
`endif

    for (int i = 0; i < 20 && (q16.size() != 0 || q4.size() != 0); i++) @(posedge clk);
    chk("q16_drained", q16.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_seq_ctrl.md
# cla_seq_ctrl

Sequencing controller that computes WIDTH-bit additions by time-multiplexing one external 4-bit carry-lookahead adder slice. Each cycle it presents one operand nibble, least significant first, and feeds the previous slice carry-out back in as carry-in. It collects the sum nibbles into a result register and returns the result over a valid/ready handshake. It sits between a requester (such as an ALU or accumulator) and the shared CLA_fulladder4 instance.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4 (elaboration error otherwise)
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  controller can accept a request
- req_a_i  input  WIDTH  operand A
- req_b_i  input  WIDTH  operand B
- req_c_i  input  1  carry-in
- rsp_valid_o  output  1  result valid
- rsp_ready_i  input  1  requester accepts result
- rsp_sum_o  output  WIDTH  sum
- rsp_c_o  output  1  final carry-out
- busy_o  output  1  high in RUN or DONE
- add_a_o  output  4  nibble of A to adder slice
- add_b_o  output  4  nibble of B to adder slice
- add_c_o  output  1  carry-in to adder slice
- add_sum_i  input  4  slice sum (combinational from add_*_o)
- add_c_i  input  1  slice carry-out

## Operation
- NIB = WIDTH/4. Internal state: A/B operand regs, carry reg, result reg, nibble index (clog2(NIB) bits, min 1), FSM.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch A, B, and req_c_i into the carry reg; set idx=0; go to RUN.
- RUN
  - add_a_o = A[4*idx+:4], add_b_o = B[4*idx+:4], add_c_o = carry reg.
  - On each edge: result[4*idx+:4] ← add_sum_i, carry ← add_c_i, idx ← idx+1.
  - When idx==NIB-1, go to DONE instead of incrementing past the end.
- DONE
  - rsp_valid_o=1; rsp_sum_o=result, rsp_c_o=carry reg, both held stable.
  - On rsp_ready_i, go to IDLE.
- add_a_o/add_b_o/add_c_o are driven 0 outside RUN.
- req_ready_o is 0 in RUN and DONE. Requests presented then are ignored, not queued.
- rsp_sum_o/rsp_c_o hold their last value in IDLE. Outside DONE they are qualified only by rsp_valid_o.
- Arithmetic: {rsp_c_o, rsp_sum_o} = A + B + cin, modulo 2^(WIDTH+1). Never truncated.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - FSM=IDLE, idx=0, all regs cleared.
  - Outputs: req_ready_o=1, rsp_valid_o=0, rsp_sum_o=0, rsp_c_o=0, busy_o=0, add_*_o=0.
  - An in-flight operation is discarded and no response is produced.
- Latency: the accept edge is edge 0. RUN occupies edges 1..NIB, with one nibble captured per edge. rsp_valid_o is high after edge NIB.
- Throughput: one operation per NIB+2 cycles minimum (accept, NIB RUN cycles, DONE with rsp_ready_i=1).
- WIDTH=4: a single RUN cycle; rsp_valid_o rises one edge after acceptance.
- Response backpressure: DONE persists indefinitely while rsp_ready_i=0, with outputs stable.
- After a DONE→IDLE edge, req_ready_o=1 in the next cycle. No same-cycle turnaround.
- The slice path is combinational: add_*_o → add_sum_i/add_c_i must settle within one clock period.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - Adds input port req_sub_i (1 bit), latched at acceptance.
  - When set, B is stored as ~req_b_i and the carry reg is initialised to 1 (req_c_i ignored).
  - Result is A − B, and rsp_c_o=1 means no borrow.
- CLA_SEQ_SUB_EN undefined: port absent; addition only.

## Test plan
- WIDTH=16, A=0x1234, B=0x4321, cin=0 → rsp_sum_o=0x5555, rsp_c_o=0; rsp_valid_o high exactly 4 edges after acceptance.
- WIDTH=16, A=0xFFFF, B=0x0001, cin=0 → sum=0x0000, c=1; add_c_o observed as 0,1,1,1 across RUN cycles.
- Backpressure: hold rsp_ready_i=0 for 10 cycles after DONE → rsp_valid_o/sum stable, req_ready_o=0, new req_valid_i ignored; release → IDLE next cycle.
- Reset mid-RUN (assert rst_ni low after 2 nibbles) → all outputs at reset values immediately; no rsp_valid_o afterwards; next request A=0x0F0F, B=0x00F1 → sum=0x1000, c=0.
- WIDTH=4, A=0xF, B=0xF, cin=1 → sum=0xF, c=1 one edge after acceptance.
- With CLA_SEQ_SUB_EN, WIDTH=16, A=0x0005, B=0x0007, sub=1 → sum=0xFFFE, c=0; A=0x0007, B=0x0005 → sum=0x0002, c=1.
